bolme_divider: RTL and testbench

Sequential 4-bit unsigned integer divider (`bolme` DUT) computing quotient and remainder of a dividend by a divisor with a restoring shift-subtract algorithm, one quotient bit per clock. Sits as a small arithmetic coprocessor behind a start/done handshake. Includes explicit divide-by-zero detection.

---
 rtl/bolme_divider.sv | 120 ++++++++++++
 tb/tb_bolme_divider.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bolme_divider.sv
// 4-bit unsigned restoring divider, one quotient bit per clock behind a start/done handshake.
// Divide-by-zero returns quotient 4'hF, remainder = dividend and raises divisor_zero.
//
// state | meaning
// IDLE  | waiting for start, operands latched on acceptance
// CALC  | shift-subtract, one quotient bit per cycle, MSB first
// DONE  | result ready internally; published with the done pulse on exit
module bolme_divider (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] bolunen,
    input  logic [3:0] bolen,
    output logic [3:0] kalan,
    output logic [3:0] bolum,
    output logic       done,
    output logic       divisor_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [4:0] rem;
    logic [3:0] dvd;
    logic [3:0] dvs;
    logic [3:0] quo;
    logic [1:0] cnt;
    logic       dz_pend;
    logic [4:0] rem_shift;
    logic [4:0] rem_sub;
    logic       fits;

    always_comb begin
        rem_shift = {rem[3:0], dvd[3]};
        fits      = (rem_shift >= {1'b0, dvs});
        rem_sub   = rem_shift - {1'b0, dvs};
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (bolen == 4'd0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == 2'd0) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Outputs are published on the DONE->IDLE edge so done and the result move together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem          <= 5'd0;
            dvd          <= 4'd0;
            dvs          <= 4'd0;
            quo          <= 4'd0;
            cnt          <= 2'd0;
            dz_pend      <= 1'b0;
            bolum        <= 4'd0;
            kalan        <= 4'd0;
            done         <= 1'b0;
            divisor_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvs <= bolen;
                        if (bolen == 4'd0) begin
                            quo     <= 4'hF;
                            rem     <= {1'b0, bolunen};
                            dvd     <= 4'd0;
                            dz_pend <= 1'b1;
                        end else begin
                            quo     <= 4'd0;
                            rem     <= 5'd0;
                            dvd     <= bolunen;
                            cnt     <= 2'd3;
                            dz_pend <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem <= fits ? rem_sub : rem_shift;
                    dvd <= {dvd[2:0], 1'b0};
                    quo <= {quo[2:0], fits};
                    cnt <= cnt - 2'd1;
                end
                DONE: begin
                    bolum        <= quo;
                    kalan        <= rem[3:0];
                    divisor_zero <= dz_pend;
                    done         <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bolme_divider.sv
// Self-checking bench for bolme_divider: directed cases, exhaustive nonzero pairs and
// random operations against an arithmetic quotient/remainder model.
module tb_bolme_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] bolunen;
    logic [3:0] bolen;
    logic [3:0] kalan;
    logic [3:0] bolum;
    logic       done;
    logic       divisor_zero;

    int n_checks = 0;
    int n_errors = 0;

    bolme_divider dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bolunen      (bolunen),
        .bolen        (bolen),
        .kalan        (kalan),
        .bolum        (bolum),
        .done         (done),
        .divisor_zero (divisor_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start one operation from IDLE and check latency, result and hold behaviour.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input string tag);
        int         lat;
        int         exp_lat;
        logic [3:0] eq;
        logic [3:0] er;
        logic       ez;
        if (b == 4'd0) begin
            eq = 4'hF; er = a; ez = 1'b1; exp_lat = 1;
        end else begin
            eq = a / b; er = a % b; ez = 1'b0; exp_lat = 5;
        end
        bolunen = a;
        bolen   = b;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        bolunen = 4'($urandom);
        bolen   = 4'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 8'(lat), 8'(exp_lat));
        check({tag, "_bolum"}, {4'd0, bolum}, {4'd0, eq});
        check({tag, "_kalan"}, {4'd0, kalan}, {4'd0, er});
        check({tag, "_dz"}, {7'd0, divisor_zero}, {7'd0, ez});
        @(posedge clk);
        #1;
        check({tag, "_done_fall"}, {7'd0, done}, 8'd0);
        check({tag, "_hold_q"}, {4'd0, bolum}, {4'd0, eq});
        check({tag, "_hold_r"}, {4'd0, kalan}, {4'd0, er});
    endtask

    initial begin
        int         done_cnt;
        int         first_done;
        int         second_done;
        logic [3:0] ra;
        logic [3:0] rb;

        rst     = 1'b1;
        start   = 1'b0;
        bolunen = 4'd0;
        bolen   = 4'd0;
        #1;
        check("reset_bolum", {4'd0, bolum}, 8'd0);
        check("reset_kalan", {4'd0, kalan}, 8'd0);
        check("reset_done", {7'd0, done}, 8'd0);
        check("reset_dz", {7'd0, divisor_zero}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(4'd15, 4'd2, "d15_2");

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_bolum", {4'd0, bolum}, 8'd0);
        check("async_rst_kalan", {4'd0, kalan}, 8'd0);
        check("async_rst_done", {7'd0, done}, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(4'd9, 4'd0, "d9_0");
        run_op(4'd9, 4'd9, "d9_9");
        run_op(4'd3, 4'd7, "d3_7");
        run_op(4'd0, 4'd5, "d0_5");
        run_op(4'd15, 4'd1, "d15_1");
        run_op(4'd15, 4'd15, "d15_15");

        // start held high: back-to-back operations, operand change in CALC ignored.
        bolunen     = 4'd15;
        bolen       = 4'd2;
        start       = 1'b1;
        done_cnt    = 0;
        first_done  = -1;
        second_done = -1;
        for (int e = 0; e < 14; e++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = e;
                else if (second_done < 0) second_done = e;
                check("b2b_bolum", {4'd0, bolum}, 8'd7);
                check("b2b_kalan", {4'd0, kalan}, 8'd1);
            end
            if (e == 1) begin
                bolunen = 4'd3;
                bolen   = 4'd1;
            end
            if (e == 4) begin
                bolunen = 4'd15;
                bolen   = 4'd2;
            end
            if (e == 9) start = 1'b0;
        end
        check("b2b_done_count", 8'(done_cnt), 8'd2);
        check("b2b_first_done", 8'(first_done), 8'd5);
        check("b2b_period", 8'(second_done - first_done), 8'd6);

        // Reset at E3 of a 14/3 operation aborts it.
        bolunen = 4'd14;
        bolen   = 4'd3;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_bolum", {4'd0, bolum}, 8'd0);
        check("abort_kalan", {4'd0, kalan}, 8'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("abort_no_done", {7'd0, done}, 8'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(4'd14, 4'd3, "d14_3");

        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op(4'(a), 4'(b), "exh");
            end
        end

        for (int k = 0; k < 40; k++) begin
            ra = 4'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            run_op(ra, rb, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
